tlb_cam_asid: RTL and testbench

Parametrised, ASID-tagged fully-associative TLB array for the Sv32 MMU, the next generation of the 32-entry lookup CAM. It adds:
- configurable depth and field widths;
- ASID and global-bit matching;
- automatic victim selection on fill;
- an `sfence.vma`-style sequential flush engine;
- hit/miss/multi-hit statistics.

It sits between the page-table walker (fill, flush) and the I/D address-translation path (lookup).

---
 rtl/tlb_pkg.sv | 24 ++
 rtl/tlb_cam_asid_if.sv | 64 ++++++
 rtl/tlb_prio_enc.sv | 27 ++
 rtl/tlb_cam_asid.sv | 249 ++++++++++++++++++++++++
 tb/tb_tlb_cam_asid.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the Sv32 TLB CAM: permission bit layout, default
// field widths and the flush engine state encoding.
package tlb_pkg;

    localparam int PERM_V = 0;
    localparam int PERM_R = 1;
    localparam int PERM_W = 2;
    localparam int PERM_X = 3;
    localparam int PERM_U = 4;
    localparam int PERM_G = 5;
    localparam int PERM_A = 6;
    localparam int PERM_D = 7;
    localparam int PERM_BITS = 8;

    localparam int VPN_W_DEF  = 20;
    localparam int PPN_W_DEF  = 22;
    localparam int ASID_W_DEF = 9;

    typedef enum logic [0:0] {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_e;

endpackage

// File: rtl/tlb_cam_asid_if.sv
// Bundle of lookup, fill, flush and statistics signals between the MMU
// clients (master) and the TLB array (slave).
interface tlb_cam_asid_if
    import tlb_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int VPN_W  = VPN_W_DEF,
    parameter int PPN_W  = PPN_W_DEF,
    parameter int ASID_W = ASID_W_DEF,
    parameter int CNT_W  = 32,
    localparam int IDX_W = $clog2(DEPTH)
);
    logic                 lookup_valid;
    logic [VPN_W-1:0]     lookup_vpn;
    logic [ASID_W-1:0]    lookup_asid;
    logic                 rsp_valid;
    logic                 rsp_hit;
    logic                 rsp_miss;
    logic                 rsp_multi;
    logic [PPN_W-1:0]     rsp_ppn;
    logic [PERM_BITS-1:0] rsp_perm;
    logic [IDX_W-1:0]     rsp_idx;

    logic                 fill_valid;
    logic                 fill_ready;
    logic [VPN_W-1:0]     fill_vpn;
    logic [ASID_W-1:0]    fill_asid;
    logic [PPN_W-1:0]     fill_ppn;
    logic [PERM_BITS-1:0] fill_perm;
    logic [IDX_W-1:0]     fill_idx;

    logic                 flush_req;
    logic                 flush_use_vpn;
    logic                 flush_use_asid;
    logic [VPN_W-1:0]     flush_vpn;
    logic [ASID_W-1:0]    flush_asid;
    logic                 flush_busy;
    logic                 flush_done;

    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     miss_cnt;
    logic [CNT_W-1:0]     multi_cnt;

    modport master (
        output lookup_valid, lookup_vpn, lookup_asid,
        input  rsp_valid, rsp_hit, rsp_miss, rsp_multi, rsp_ppn, rsp_perm, rsp_idx,
        output fill_valid, fill_vpn, fill_asid, fill_ppn, fill_perm,
        input  fill_ready, fill_idx,
        output flush_req, flush_use_vpn, flush_use_asid, flush_vpn, flush_asid,
        input  flush_busy, flush_done,
        input  hit_cnt, miss_cnt, multi_cnt
    );

    modport slave (
        input  lookup_valid, lookup_vpn, lookup_asid,
        output rsp_valid, rsp_hit, rsp_miss, rsp_multi, rsp_ppn, rsp_perm, rsp_idx,
        input  fill_valid, fill_vpn, fill_asid, fill_ppn, fill_perm,
        output fill_ready, fill_idx,
        input  flush_req, flush_use_vpn, flush_use_asid, flush_vpn, flush_asid,
        output flush_busy, flush_done,
        output hit_cnt, miss_cnt, multi_cnt
    );

endinterface

// File: rtl/tlb_prio_enc.sv
// Lowest-index priority encoder with any-set and more-than-one-set flags.
module tlb_prio_enc
    import tlb_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any   = |vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - DEPTH'(1)));

endmodule

// File: rtl/tlb_cam_asid.sv
// ASID-tagged fully-associative Sv32 TLB: single-cycle CAM lookup, victim
// selection on fill, sequential qualified flush and hit/miss statistics.
module tlb_cam_asid
    import tlb_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int VPN_W  = VPN_W_DEF,
    parameter int PPN_W  = PPN_W_DEF,
    parameter int ASID_W = ASID_W_DEF,
    parameter int CNT_W  = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    tlb_cam_asid_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [VPN_W-1:0]     vpn_arr  [DEPTH];
    logic [ASID_W-1:0]    asid_arr [DEPTH];
    logic [PPN_W-1:0]     ppn_arr  [DEPTH];
    logic [PERM_BITS-1:0] perm_arr [DEPTH];
    logic [DEPTH-1:0]     match_vec;
    logic [DEPTH-1:0]     free_vec;

    flush_state_e      state_q, state_d;
    logic [IDX_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [VPN_W-1:0]  fvpn_q, fvpn_d;
    logic [ASID_W-1:0] fasid_q, fasid_d;
    logic              use_vpn_q, use_vpn_d;
    logic              use_asid_q, use_asid_d;

    logic busy, sweep_last, flush_accept, sweep_kill, fill_fire;
    logic [IDX_W-1:0] victim_idx, hit_idx, free_idx;
    logic hit_any, hit_multi, free_any, free_multi;
    logic lk_hit;

    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic                 rsp_miss_q, rsp_miss_d;
    logic                 rsp_multi_q, rsp_multi_d;
    logic [PPN_W-1:0]     rsp_ppn_q, rsp_ppn_d;
    logic [PERM_BITS-1:0] rsp_perm_q, rsp_perm_d;
    logic [IDX_W-1:0]     rsp_idx_q, rsp_idx_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]     multi_cnt_q, multi_cnt_d;

    genvar gi;

    // Entry storage: fills are only accepted while idle, so a write and a
    // sweep invalidation never target an entry in the same cycle.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [VPN_W-1:0]     vpn_q, vpn_d;
            logic [ASID_W-1:0]    asid_q, asid_d;
            logic [PPN_W-1:0]     ppn_q, ppn_d;
            logic [PERM_BITS-1:0] perm_q, perm_d;
            logic                 wr_en, kill_en;

            assign wr_en   = fill_fire && (victim_idx == IDX_W'(gi));
            assign kill_en = sweep_kill && (sp_q == IDX_W'(gi));

            always_comb begin
                vpn_d  = vpn_q;
                asid_d = asid_q;
                ppn_d  = ppn_q;
                perm_d = perm_q;
                if (wr_en) begin
                    vpn_d  = bus.fill_vpn;
                    asid_d = bus.fill_asid;
                    ppn_d  = bus.fill_ppn;
                    perm_d = bus.fill_perm;
                end else if (kill_en) begin
                    perm_d[PERM_V] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vpn_q  <= '0;
                    asid_q <= '0;
                    ppn_q  <= '0;
                    perm_q <= '0;
                end else begin
                    vpn_q  <= vpn_d;
                    asid_q <= asid_d;
                    ppn_q  <= ppn_d;
                    perm_q <= perm_d;
                end
            end

            assign vpn_arr[gi]   = vpn_q;
            assign asid_arr[gi]  = asid_q;
            assign ppn_arr[gi]   = ppn_q;
            assign perm_arr[gi]  = perm_q;
            assign free_vec[gi]  = ~perm_q[PERM_V];
            assign match_vec[gi] = perm_q[PERM_V] && (vpn_q == bus.lookup_vpn)
                                   && (perm_q[PERM_G] || (asid_q == bus.lookup_asid));
        end
    endgenerate

    tlb_prio_enc #(.DEPTH(DEPTH)) u_match_enc (
        .vec   (match_vec),
        .idx   (hit_idx),
        .any   (hit_any),
        .multi (hit_multi)
    );

    tlb_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
        .vec   (free_vec),
        .idx   (free_idx),
        .any   (free_any),
        .multi (free_multi)
    );

    logic unused_free_multi;
    assign unused_free_multi = free_multi;

    // Flush engine: state register, next-state logic, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FL_IDLE:  if (bus.flush_req) state_d = FL_SWEEP;
            FL_SWEEP: if (sp_q == LAST_IDX) state_d = FL_IDLE;
            default:  state_d = FL_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == FL_SWEEP);
        sweep_last   = (state_q == FL_SWEEP) && (sp_q == LAST_IDX);
        flush_accept = (state_q == FL_IDLE) && bus.flush_req;
    end

    // Qualifiers are frozen at acceptance so a later flush_req cannot alter a sweep.
    always_comb begin
        sp_d       = sp_q;
        fvpn_d     = fvpn_q;
        fasid_d    = fasid_q;
        use_vpn_d  = use_vpn_q;
        use_asid_d = use_asid_q;
        if (flush_accept) begin
            sp_d       = '0;
            fvpn_d     = bus.flush_vpn;
            fasid_d    = bus.flush_asid;
            use_vpn_d  = bus.flush_use_vpn;
            use_asid_d = bus.flush_use_asid;
        end else if (busy) begin
            sp_d = sp_q + 1'b1;
        end
    end

    assign sweep_kill = busy
                        && (!use_vpn_q || (vpn_arr[sp_q] == fvpn_q))
                        && (!use_asid_q || (!perm_arr[sp_q][PERM_G] && (asid_arr[sp_q] == fasid_q)));

    // Victim: first free slot, else the round-robin pointer.
    assign fill_fire  = bus.fill_valid && !busy;
    assign victim_idx = free_any ? free_idx : rr_q;

    always_comb begin
        rr_d = rr_q;
        if (sweep_last) begin
            rr_d = '0;
        end else if (fill_fire && !free_any) begin
            rr_d = rr_q + 1'b1;
        end
    end

    // Counters advance on the same edge that registers the response.
    always_comb begin
        lk_hit      = bus.lookup_valid && !busy && hit_any;
        rsp_valid_d = bus.lookup_valid;
        rsp_hit_d   = lk_hit;
        rsp_miss_d  = bus.lookup_valid && !lk_hit;
        rsp_multi_d = lk_hit && hit_multi;
        rsp_ppn_d   = lk_hit ? ppn_arr[hit_idx] : '0;
        rsp_perm_d  = lk_hit ? perm_arr[hit_idx] : '0;
        rsp_idx_d   = lk_hit ? hit_idx : '0;
        hit_cnt_d   = hit_cnt_q + CNT_W'(rsp_hit_d);
        miss_cnt_d  = miss_cnt_q + CNT_W'(rsp_miss_d);
        multi_cnt_d = multi_cnt_q + CNT_W'(rsp_multi_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '0;
            rr_q        <= '0;
            fvpn_q      <= '0;
            fasid_q     <= '0;
            use_vpn_q   <= 1'b0;
            use_asid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_miss_q  <= 1'b0;
            rsp_multi_q <= 1'b0;
            rsp_ppn_q   <= '0;
            rsp_perm_q  <= '0;
            rsp_idx_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            multi_cnt_q <= '0;
        end else begin
            sp_q        <= sp_d;
            rr_q        <= rr_d;
            fvpn_q      <= fvpn_d;
            fasid_q     <= fasid_d;
            use_vpn_q   <= use_vpn_d;
            use_asid_q  <= use_asid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_miss_q  <= rsp_miss_d;
            rsp_multi_q <= rsp_multi_d;
            rsp_ppn_q   <= rsp_ppn_d;
            rsp_perm_q  <= rsp_perm_d;
            rsp_idx_q   <= rsp_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            multi_cnt_q <= multi_cnt_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_miss   = rsp_miss_q;
    assign bus.rsp_multi  = rsp_multi_q;
    assign bus.rsp_ppn    = rsp_ppn_q;
    assign bus.rsp_perm   = rsp_perm_q;
    assign bus.rsp_idx    = rsp_idx_q;
    assign bus.fill_ready = !busy;
    assign bus.fill_idx   = victim_idx;
    assign bus.flush_busy = busy;
    assign bus.flush_done = sweep_last;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
    assign bus.multi_cnt  = multi_cnt_q;

endmodule

// File: tb/tb_tlb_cam_asid.sv
// Directed bench for tlb_cam_asid: stimulus pushes expected lookup responses
// into a queue, a negedge monitor pops and compares them.
module tb_tlb_cam_asid;

    localparam int D = 32;

    logic clk;
    logic rst;

    tlb_cam_asid_if #(.DEPTH(D), .VPN_W(20), .PPN_W(22), .ASID_W(9), .CNT_W(32)) bus ();

    tlb_cam_asid #(.DEPTH(D), .VPN_W(20), .PPN_W(22), .ASID_W(9), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        multi;
        logic [21:0] ppn;
        logic [7:0]  perm;
        logic [4:0]  idx;
        logic [31:0] hc;
        logic [31:0] mc;
        logic [31:0] xc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hc = 0, m_mc = 0, m_xc = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.lookup_valid   = 1'b0;
        bus.fill_valid     = 1'b0;
        bus.flush_req      = 1'b0;
        bus.flush_use_vpn  = 1'b0;
        bus.flush_use_asid = 1'b0;
    endtask

    task automatic issue_lookup(input logic [19:0] vpn, input logic [8:0] asid,
                                input logic hit, input logic multi, input logic [21:0] ppn,
                                input logic [7:0] perm, input logic [4:0] idx);
        exp_t e;
        bus.lookup_valid = 1'b1;
        bus.lookup_vpn   = vpn;
        bus.lookup_asid  = asid;
        if (hit) m_hc++; else m_mc++;
        if (multi) m_xc++;
        e.hit = hit; e.multi = multi; e.ppn = ppn; e.perm = perm; e.idx = idx;
        e.hc = m_hc; e.mc = m_mc; e.xc = m_xc;
        exp_q.push_back(e);
    endtask

    task automatic do_lookup(input logic [19:0] vpn, input logic [8:0] asid,
                             input logic hit, input logic multi, input logic [21:0] ppn,
                             input logic [7:0] perm, input logic [4:0] idx);
        issue_lookup(vpn, asid, hit, multi, ppn, perm, idx);
        tick();
        clear();
    endtask

    task automatic issue_fill(input logic [19:0] vpn, input logic [8:0] asid,
                              input logic [21:0] ppn, input logic [7:0] perm, input logic [4:0] exp_idx);
        bus.fill_valid = 1'b1;
        bus.fill_vpn   = vpn;
        bus.fill_asid  = asid;
        bus.fill_ppn   = ppn;
        bus.fill_perm  = perm;
        chk("fill_ready", bus.fill_ready, 1'b1);
        chk("fill_idx", bus.fill_idx, exp_idx);
        $display("[%0t] fill vpn=0x%05h asid=%0d ppn=0x%06h perm=0x%02h idx=%0d",
                 $time, vpn, asid, ppn, perm, bus.fill_idx);
    endtask

    task automatic do_fill(input logic [19:0] vpn, input logic [8:0] asid,
                           input logic [21:0] ppn, input logic [7:0] perm, input logic [4:0] exp_idx);
        issue_fill(vpn, asid, ppn, perm, exp_idx);
        tick();
        clear();
    endtask

    task automatic issue_flush(input logic uv, input logic ua, input logic [19:0] v, input logic [8:0] a);
        bus.flush_req      = 1'b1;
        bus.flush_use_vpn  = uv;
        bus.flush_use_asid = ua;
        bus.flush_vpn      = v;
        bus.flush_asid     = a;
        $display("[%0t] flush use_vpn=%0b use_asid=%0b vpn=0x%05h asid=%0d", $time, uv, ua, v, a);
    endtask

    task automatic flush_and_wait(input logic uv, input logic ua, input logic [19:0] v, input logic [8:0] a);
        issue_flush(uv, ua, v, a);
        tick();
        clear();
        for (int c = 1; c <= D; c++) begin
            chk("sweep_busy", bus.flush_busy, 1'b1);
            chk("sweep_fill_ready", bus.fill_ready, 1'b0);
            chk("sweep_done", bus.flush_done, (c == D));
            tick();
        end
        chk("post_sweep_busy", bus.flush_busy, 1'b0);
        chk("post_sweep_done", bus.flush_done, 1'b0);
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("[%0t] rsp hit=%0b miss=%0b multi=%0b idx=%0d ppn=0x%06h perm=0x%02h cnt=%0d/%0d/%0d",
                             $time, bus.rsp_hit, bus.rsp_miss, bus.rsp_multi, bus.rsp_idx,
                             bus.rsp_ppn, bus.rsp_perm, bus.hit_cnt, bus.miss_cnt, bus.multi_cnt);
                    chk("rsp_hit", bus.rsp_hit, e.hit);
                    chk("rsp_miss", bus.rsp_miss, !e.hit);
                    chk("rsp_multi", bus.rsp_multi, e.multi);
                    chk("rsp_ppn", bus.rsp_ppn, e.ppn);
                    chk("rsp_perm", bus.rsp_perm, e.perm);
                    chk("rsp_idx", bus.rsp_idx, e.idx);
                    chk("hit_cnt", bus.hit_cnt, e.hc);
                    chk("miss_cnt", bus.miss_cnt, e.mc);
                    chk("multi_cnt", bus.multi_cnt, e.xc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear();
        bus.lookup_vpn = '0; bus.lookup_asid = '0;
        bus.fill_vpn = '0; bus.fill_asid = '0; bus.fill_ppn = '0; bus.fill_perm = '0;
        bus.flush_vpn = '0; bus.flush_asid = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_hit", bus.rsp_hit, 1'b0);
        chk("rst_rsp_miss", bus.rsp_miss, 1'b0);
        chk("rst_flush_busy", bus.flush_busy, 1'b0);
        chk("rst_flush_done", bus.flush_done, 1'b0);
        chk("rst_fill_ready", bus.fill_ready, 1'b1);
        chk("rst_fill_idx", bus.fill_idx, 5'd0);
        chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
        chk("rst_multi_cnt", bus.multi_cnt, 32'd0);

        // Basic hit, ASID mismatch, global entry, multi-hit on overlap
        do_fill(20'h12345, 9'd3, 22'h2ABCD, 8'h0F, 5'd0);
        do_lookup(20'h12345, 9'd3, 1'b1, 1'b0, 22'h2ABCD, 8'h0F, 5'd0);
        tick();
        chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
        chk("idle_rsp_hit", bus.rsp_hit, 1'b0);
        chk("idle_rsp_miss", bus.rsp_miss, 1'b0);
        do_lookup(20'h12345, 9'd4, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_fill(20'h12345, 9'd7, 22'h11111, 8'h2F, 5'd1);
        do_lookup(20'h12345, 9'd9, 1'b1, 1'b0, 22'h11111, 8'h2F, 5'd1);
        do_lookup(20'h12345, 9'd3, 1'b1, 1'b1, 22'h2ABCD, 8'h0F, 5'd0);

        // Lookup in the same cycle as a fill sees the old contents
        issue_lookup(20'h0ABCD, 9'd5, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        issue_fill(20'h0ABCD, 9'd5, 22'h00003, 8'h0F, 5'd2);
        tick();
        clear();
        do_lookup(20'h0ABCD, 9'd5, 1'b1, 1'b0, 22'h00003, 8'h0F, 5'd2);

        // Round-robin replacement after a full flush
        flush_and_wait(1'b0, 1'b0, 20'h0, 9'd0);
        for (int i = 0; i < D; i++) begin
            do_fill(20'h00100 + 20'(i), 9'd1, 22'h00200 + 22'(i), 8'h0F, 5'(i));
        end
        for (int k = 0; k < 3; k++) begin
            do_fill(20'h00300 + 20'(k), 9'd1, 22'h00400 + 22'(k), 8'h0F, 5'(k));
        end
        chk("rr_next_idx", bus.fill_idx, 5'd3);
        do_lookup(20'h00100, 9'd1, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h00102, 9'd1, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h00103, 9'd1, 1'b1, 1'b0, 22'h00203, 8'h0F, 5'd3);
        do_lookup(20'h00103, 9'd2, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h0011F, 9'd1, 1'b1, 1'b0, 22'h0021F, 8'h0F, 5'd31);
        do_lookup(20'h00300, 9'd1, 1'b1, 1'b0, 22'h00400, 8'h0F, 5'd0);
        do_lookup(20'h00302, 9'd1, 1'b1, 1'b0, 22'h00402, 8'h0F, 5'd2);

        // Multi-hit: lowest index wins
        flush_and_wait(1'b0, 1'b0, 20'h0, 9'd0);
        do_fill(20'h00010, 9'd1, 22'h00AAA, 8'h0F, 5'd0);
        for (int i = 1; i < 5; i++) begin
            do_fill(20'h0001F + 20'(i), 9'd1, 22'h00020 + 22'(i), 8'h0F, 5'(i));
        end
        do_fill(20'h00010, 9'd1, 22'h00BBB, 8'h0F, 5'd5);
        do_lookup(20'h00010, 9'd1, 1'b1, 1'b1, 22'h00AAA, 8'h0F, 5'd0);

        // ASID flush with same-cycle fill and lookup, stray flush_req and fill while busy
        flush_and_wait(1'b0, 1'b0, 20'h0, 9'd0);
        do_fill(20'h00050, 9'd2, 22'h000A0, 8'h2F, 5'd0);
        do_fill(20'h00051, 9'd2, 22'h000B0, 8'h0F, 5'd1);
        do_fill(20'h00052, 9'd3, 22'h000C0, 8'h0F, 5'd2);
        issue_fill(20'h00053, 9'd2, 22'h000D0, 8'h0F, 5'd3);
        issue_lookup(20'h00050, 9'd9, 1'b1, 1'b0, 22'h000A0, 8'h2F, 5'd0);
        issue_flush(1'b0, 1'b1, 20'h00051, 9'd2);
        tick();
        clear();
        for (int c = 1; c <= D; c++) begin
            chk("asid_busy", bus.flush_busy, 1'b1);
            chk("asid_fill_ready", bus.fill_ready, 1'b0);
            chk("asid_done", bus.flush_done, (c == D));
            issue_lookup(20'h00050, 9'd2, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
            if (c == 5) issue_flush(1'b0, 1'b0, 20'h0, 9'd0);
            if (c == 7) begin
                bus.fill_valid = 1'b1;
                bus.fill_vpn   = 20'h00060;
                bus.fill_asid  = 9'd3;
                bus.fill_ppn   = 22'h000E0;
                bus.fill_perm  = 8'h0F;
            end
            tick();
            clear();
        end
        chk("asid_post_busy", bus.flush_busy, 1'b0);
        chk("asid_post_done", bus.flush_done, 1'b0);
        chk("asid_post_ready", bus.fill_ready, 1'b1);
        do_lookup(20'h00050, 9'd2, 1'b1, 1'b0, 22'h000A0, 8'h2F, 5'd0);
        do_lookup(20'h00051, 9'd2, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h00052, 9'd3, 1'b1, 1'b0, 22'h000C0, 8'h0F, 5'd2);
        do_lookup(20'h00053, 9'd2, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h00060, 9'd3, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        chk("asid_free_idx", bus.fill_idx, 5'd1);

        // Reset on sweep cycle 10 of a flush that matches nothing
        tick();
        tick();
        issue_flush(1'b1, 1'b0, 20'h07777, 9'd0);
        tick();
        clear();
        for (int c = 1; c < 10; c++) begin
            chk("rstmid_busy", bus.flush_busy, 1'b1);
            chk("rstmid_done", bus.flush_done, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hc = 0; m_mc = 0; m_xc = 0;
        chk("rstmid_busy_after", bus.flush_busy, 1'b0);
        chk("rstmid_done_after", bus.flush_done, 1'b0);
        chk("rstmid_ready_after", bus.fill_ready, 1'b1);
        chk("rstmid_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rstmid_miss_cnt", bus.miss_cnt, 32'd0);
        chk("rstmid_multi_cnt", bus.multi_cnt, 32'd0);
        chk("rstmid_fill_idx", bus.fill_idx, 5'd0);
        tick();
        chk("rstmid_done_late", bus.flush_done, 1'b0);
        do_lookup(20'h00050, 9'd2, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);
        do_lookup(20'h00052, 9'd3, 1'b0, 1'b0, 22'h0, 8'h0, 5'd0);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
